// File: rtl/controle_decripta.sv
// Iterative AES-128 inverse-cipher round sequencer: holds the state, issues one
// inverse operation per cycle to an external combinational stage bank, returns plaintext.
module controle_decripta #(
  parameter int unsigned NUM_RODADAS = 10  // 1..15, key indices NUM_RODADAS..0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inicio,
  input  logic [127:0] bloco_in,
  output logic         ocupado,
  output logic         valido,
  input  logic         aceito,
  output logic [127:0] bloco_out,
  output logic [127:0] dp_bloco,
  output logic [1:0]   dp_op,
  input  logic [127:0] dp_saida,
  output logic [3:0]   idx_chave,
  input  logic [127:0] chave
);

  localparam logic [1:0] OP_ARK = 2'd0;
  localparam logic [1:0] OP_SHR = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_MIX = 2'd3;
  localparam logic [3:0] RODADAS_INI = 4'(NUM_RODADAS);

  typedef enum logic [2:0] {OCIOSO, ARK0, SHR, SUB, ARK, MIX, ARKF, FIM} st_e;

  st_e          st_q, st_d;
  logic [127:0] estado_q, estado_d;
  logic [3:0]   rodada_q, rodada_d;
  logic         ocupado_q, ocupado_d;
  logic         valido_q, valido_d;
  logic [127:0] bloco_out_q, bloco_out_d;

  // The round key goes straight from the key store to the datapath.
  logic unused_chave;
  assign unused_chave = ^chave;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= OCIOSO;
      estado_q    <= '0;
      rodada_q    <= '0;
      ocupado_q   <= 1'b0;
      valido_q    <= 1'b0;
      bloco_out_q <= '0;
    end else begin
      st_q        <= st_d;
      estado_q    <= estado_d;
      rodada_q    <= rodada_d;
      ocupado_q   <= ocupado_d;
      valido_q    <= valido_d;
      bloco_out_q <= bloco_out_d;
    end
  end

  always_comb begin
    st_d        = st_q;
    estado_d    = estado_q;
    rodada_d    = rodada_q;
    ocupado_d   = ocupado_q;
    valido_d    = valido_q;
    bloco_out_d = bloco_out_q;
    unique case (st_q)
      OCIOSO: if (inicio) begin
        estado_d  = bloco_in;
        rodada_d  = RODADAS_INI;
        ocupado_d = 1'b1;
        st_d      = ARK0;
      end
      ARK0: begin
        estado_d = dp_saida;
        rodada_d = rodada_q - 4'd1;
        st_d     = SHR;
      end
      SHR: begin
        estado_d = dp_saida;
        st_d     = SUB;
      end
      // rodada reaches 0 only after the last MIX, so the final round skips ARK/MIX
      SUB: begin
        estado_d = dp_saida;
        st_d     = (rodada_q == 4'd0) ? ARKF : ARK;
      end
      ARK: begin
        estado_d = dp_saida;
        st_d     = MIX;
      end
      MIX: begin
        estado_d = dp_saida;
        rodada_d = rodada_q - 4'd1;
        st_d     = SHR;
      end
      ARKF: begin
        bloco_out_d = dp_saida;
        valido_d    = 1'b1;
        st_d        = FIM;
      end
      FIM: if (aceito) begin
        valido_d  = 1'b0;
        ocupado_d = 1'b0;
        st_d      = OCIOSO;
      end
      default: st_d = OCIOSO;
    endcase
  end

  always_comb begin
    dp_op     = OP_ARK;
    idx_chave = '0;
    unique case (st_q)
      ARK0:    idx_chave = RODADAS_INI;
      SHR:     dp_op     = OP_SHR;
      SUB:     dp_op     = OP_SUB;
      ARK:     idx_chave = rodada_q;
      MIX:     dp_op     = OP_MIX;
      default: ;
    endcase
  end

  assign dp_bloco  = estado_q;
  assign bloco_out = bloco_out_q;
  assign ocupado   = ocupado_q;
  assign valido    = valido_q;

endmodule
